// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard controller for a 4-stage (D/RF/X/WB) 8-bit pipeline.
//            Resolves RAW hazards by forwarding the WB result.
//            Stalls one cycle on a load-use hazard.
//            Flushes D/RF/X on a taken branch evaluated in X.
//            Keeps saturating cycle and retired-instruction counters.
// Ports    : clock, reset           - clock, synchronous active-high reset
//            step_en                - pipeline advance enable
//            d/rf/x/wb_instr        - instructions held in each stage register
//            n_flag, z_flag         - registered ALU flags
//            pc_write, s1..s3_load,
//            wb_load                - stage register load enables
//            noop_sel1..4           - inject NOP_INSTR into D/RF/X/WB IR
//            redirect               - PC takes the branch target
//            fwd_a, fwd_b           - 0 = forward WB result, 1 = RF read data
//            state                  - FSM state (RUN=0, STALL=1, FLUSH=2)
//            cycle_cnt, retired_cnt - performance counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter logic [7:0] NOP_INSTR = 8'b00001010,
    parameter int         CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step_en,
    input  logic [7:0]       d_instr,
    input  logic [7:0]       rf_instr,
    input  logic [7:0]       x_instr,
    input  logic [7:0]       wb_instr,
    input  logic             n_flag,
    input  logic             z_flag,
    output logic             pc_write,
    output logic             s1_load,
    output logic             s2_load,
    output logic             s3_load,
    output logic             wb_load,
    output logic             noop_sel1,
    output logic             noop_sel2,
    output logic             noop_sel3,
    output logic             noop_sel4,
    output logic             redirect,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Opcode decode helpers
    // ------------------------------------------------------------------
    function automatic logic f_is_load(input logic [7:0] i);
        return i[3:0] == 4'b0000;
    endfunction

    function automatic logic f_is_ori(input logic [7:0] i);
        return i[2:0] == 3'b111;
    endfunction

    // Writers: load, add, sub, nand, ori, shift
    function automatic logic f_is_writer(input logic [7:0] i);
        return (i[3:0] == 4'b0000) || (i[3:0] == 4'b0100) ||
               (i[3:0] == 4'b0110) || (i[3:0] == 4'b1000) ||
               (i[2:0] == 3'b111)  || (i[2:0] == 3'b011);
    endfunction

    // ori implicitly targets r1; everything else names its register in [7:6]
    function automatic logic [1:0] f_dest(input logic [7:0] i);
        return f_is_ori(i) ? 2'd1 : i[7:6];
    endfunction

    // Operand A users: add, sub, nand, shift, ori, store, load
    function automatic logic f_uses_a(input logic [7:0] i);
        return (i[3:0] == 4'b0100) || (i[3:0] == 4'b0110) ||
               (i[3:0] == 4'b1000) || (i[2:0] == 3'b011)  ||
               (i[2:0] == 3'b111)  || (i[3:0] == 4'b0010) ||
               (i[3:0] == 4'b0000);
    endfunction

    // Operand B users: add, sub, nand, store, load
    function automatic logic f_uses_b(input logic [7:0] i);
        return (i[3:0] == 4'b0100) || (i[3:0] == 4'b0110) ||
               (i[3:0] == 4'b1000) || (i[3:0] == 4'b0010) ||
               (i[3:0] == 4'b0000);
    endfunction

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic       w_wb_hit_a;
    logic       w_wb_hit_b;
    logic       w_branch_taken;
    logic       w_load_use;
    logic       w_unused;

    // D stage instruction does not take part in any hazard decision
    assign w_unused = ^d_instr;

    assign w_src_a = f_is_ori(rf_instr) ? 2'd1 : rf_instr[7:6];
    assign w_src_b = rf_instr[5:4];

    assign w_wb_hit_a = f_is_writer(wb_instr) && f_uses_a(rf_instr) &&
                        (f_dest(wb_instr) == w_src_a);
    assign w_wb_hit_b = f_is_writer(wb_instr) && f_uses_b(rf_instr) &&
                        (f_dest(wb_instr) == w_src_b);

    assign fwd_a = ~w_wb_hit_a;
    assign fwd_b = ~w_wb_hit_b;

    assign w_branch_taken = ((x_instr[3:0] == 4'b0101) &  z_flag) |
                            ((x_instr[3:0] == 4'b1001) & ~z_flag) |
                            ((x_instr[3:0] == 4'b1101) & ~n_flag);

    assign w_load_use = f_is_load(x_instr) &&
                        ((f_uses_a(rf_instr) && (f_dest(x_instr) == w_src_a)) ||
                         (f_uses_b(rf_instr) && (f_dest(x_instr) == w_src_b)));

    // ------------------------------------------------------------------
    // FSM: state register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_RUN;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (step_en) begin
                if (cycle_cnt != c_CNT_MAX) begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                end
                if ((wb_instr != NOP_INSTR) && (retired_cnt != c_CNT_MAX)) begin
                    retired_cnt <= retired_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and pipeline control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        pc_write    = 1'b0;
        s1_load     = 1'b0;
        s2_load     = 1'b0;
        s3_load     = 1'b0;
        wb_load     = 1'b0;
        noop_sel1   = 1'b0;
        noop_sel2   = 1'b0;
        noop_sel3   = 1'b0;
        noop_sel4   = 1'b0;
        redirect    = 1'b0;

        if (r_state == ST_BAD) begin
            // Recover from the illegal encoding even while frozen
            w_state_nxt = ST_RUN;
        end

        if (step_en) begin
            pc_write = 1'b1;
            s1_load  = 1'b1;
            s2_load  = 1'b1;
            s3_load  = 1'b1;
            wb_load  = 1'b1;
            w_state_nxt = ST_RUN;

            if (r_state == ST_RUN) begin
                if (w_branch_taken) begin
                    // Branch wins over load-use: the dependent instruction
                    // is being squashed anyway.
                    redirect    = 1'b1;
                    noop_sel1   = 1'b1;
                    noop_sel2   = 1'b1;
                    noop_sel3   = 1'b1;
                    w_state_nxt = ST_FLUSH;
                end else if (w_load_use) begin
                    // Hold PC/D/RF, let the load advance, bubble into X
                    pc_write    = 1'b0;
                    s1_load     = 1'b0;
                    s2_load     = 1'b0;
                    noop_sel3   = 1'b1;
                    w_state_nxt = ST_STALL;
                end
            end
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] c_NOP = 8'h0A;

    logic        clk;
    logic        rst;
    logic        step_en;
    logic [7:0]  d_instr;
    logic [7:0]  rf_instr;
    logic [7:0]  x_instr;
    logic [7:0]  wb_instr;
    logic        n_flag;
    logic        z_flag;
    logic        pc_write;
    logic        s1_load;
    logic        s2_load;
    logic        s3_load;
    logic        wb_load;
    logic        noop_sel1;
    logic        noop_sel2;
    logic        noop_sel3;
    logic        noop_sel4;
    logic        redirect;
    logic        fwd_a;
    logic        fwd_b;
    logic [1:0]  state;
    logic [15:0] cycle_cnt;
    logic [15:0] retired_cnt;

    int vectors = 0;
    int errors  = 0;

    pipe_hazard_ctrl #(
        .NOP_INSTR (c_NOP),
        .CNT_W     (16)
    ) u_dut (
        .clock       (clk),
        .reset       (rst),
        .step_en     (step_en),
        .d_instr     (d_instr),
        .rf_instr    (rf_instr),
        .x_instr     (x_instr),
        .wb_instr    (wb_instr),
        .n_flag      (n_flag),
        .z_flag      (z_flag),
        .pc_write    (pc_write),
        .s1_load     (s1_load),
        .s2_load     (s2_load),
        .s3_load     (s3_load),
        .wb_load     (wb_load),
        .noop_sel1   (noop_sel1),
        .noop_sel2   (noop_sel2),
        .noop_sel3   (noop_sel3),
        .noop_sel4   (noop_sel4),
        .redirect    (redirect),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .state       (state),
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed control view: {pc,s1,s2,s3,wb, n1,n2,n3,n4, redirect}
    function automatic logic [31:0] ctl();
        return {22'd0, pc_write, s1_load, s2_load, s3_load, wb_load,
                noop_sel1, noop_sel2, noop_sel3, noop_sel4, redirect};
    endfunction

    localparam logic [31:0] c_CTL_RUN   = 32'b11111_0000_0;
    localparam logic [31:0] c_CTL_IDLE  = 32'b00000_0000_0;
    localparam logic [31:0] c_CTL_FLUSH = 32'b11111_1110_1;
    localparam logic [31:0] c_CTL_STALL = 32'b00011_0010_0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [7:0] rf, input logic [7:0] x,
                          input logic [7:0] wb, input logic n, input logic z);
        rf_instr = rf;
        x_instr  = x;
        wb_instr = wb;
        n_flag   = n;
        z_flag   = z;
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        step_en  = 1'b1;
        d_instr  = c_NOP;
        set_in(c_NOP, c_NOP, c_NOP, 1'b0, 1'b0);
        tick();
        tick();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_cycle", 32'(cycle_cnt), 32'd0);
        chk("reset_retired", 32'(retired_cnt), 32'd0);

        // Idle pipeline of NOPs
        rst = 1'b0;
        #1;
        chk("idle_ctl", ctl(), c_CTL_RUN);
        chk("idle_fwd", {30'd0, fwd_a, fwd_b}, 32'b11);
        tick();
        chk("idle_cycle", 32'(cycle_cnt), 32'd1);
        chk("idle_retired", 32'(retired_cnt), 32'd0);

        // Forwarding: rf add r1,r2 ; wb add r2,r3 writes r2 -> operand B
        set_in(8'h64, c_NOP, 8'hB4, 1'b0, 1'b0);
        chk("fwd_ab", {30'd0, fwd_a, fwd_b}, 32'b10);
        chk("fwd_ctl", ctl(), c_CTL_RUN);
        tick();
        chk("fwd_state", 32'(state), 32'd0);
        chk("fwd_retired", 32'(retired_cnt), 32'd1);
        chk("fwd_cycle", 32'(cycle_cnt), 32'd2);

        // ori in RF reads r1; wb add r1 -> forward A only
        set_in(8'h07, c_NOP, 8'h44, 1'b0, 1'b0);
        chk("fwd_ori", {30'd0, fwd_a, fwd_b}, 32'b01);

        // Load-use: x load r1 ; rf add r0,r1
        set_in(8'h14, 8'h40, c_NOP, 1'b0, 1'b0);
        chk("lu_ctl", ctl(), c_CTL_STALL);
        tick();
        chk("lu_state", 32'(state), 32'd1);
        chk("stall_ctl", ctl(), c_CTL_RUN);
        tick();
        chk("stall_exit", 32'(state), 32'd0);

        // Frozen pipeline: taken branch ignored, state/counters hold
        set_in(c_NOP, 8'h05, c_NOP, 1'b0, 1'b1);
        step_en = 1'b0;
        #1;
        chk("frozen_ctl", ctl(), c_CTL_IDLE);
        tick();
        chk("frozen_state", 32'(state), 32'd0);
        chk("frozen_cycle", 32'(cycle_cnt), 32'd4);

        // bz taken
        step_en = 1'b1;
        #1;
        chk("bz_ctl", ctl(), c_CTL_FLUSH);
        tick();
        chk("bz_state", 32'(state), 32'd2);
        chk("flush_ctl", ctl(), c_CTL_RUN);
        tick();
        chk("flush_exit", 32'(state), 32'd0);

        // bz not taken
        set_in(c_NOP, 8'h05, c_NOP, 1'b0, 1'b0);
        chk("bz_nt_ctl", ctl(), c_CTL_RUN);
        tick();
        chk("bz_nt_state", 32'(state), 32'd0);

        // bnz taken with z=0, bpz not taken with n=1
        set_in(c_NOP, 8'h09, c_NOP, 1'b1, 1'b0);
        chk("bnz_ctl", ctl(), c_CTL_FLUSH);
        set_in(c_NOP, 8'h0D, c_NOP, 1'b1, 1'b0);
        chk("bpz_nt_ctl", ctl(), c_CTL_RUN);

        // Taken branch while RF holds a consumer of r1: a single X slot
        // cannot be both load and branch, so the branch path must win
        set_in(8'h14, 8'h0D, c_NOP, 1'b0, 1'b0);
        chk("prio_ctl", ctl(), c_CTL_FLUSH);
        tick();
        chk("prio_state", 32'(state), 32'd2);
        tick();

        // Reset during STALL
        set_in(8'h14, 8'h40, 8'hB4, 1'b0, 1'b0);
        tick();
        chk("pre_rst_stall", 32'(state), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_stall_state", 32'(state), 32'd0);
        chk("rst_stall_cycle", 32'(cycle_cnt), 32'd0);
        chk("rst_stall_retired", 32'(retired_cnt), 32'd0);
        rst = 1'b0;
        set_in(c_NOP, c_NOP, 8'hB4, 1'b0, 1'b0);
        tick();
        chk("post_rst_state", 32'(state), 32'd0);

        // Saturation: 1 cycle already counted, bring to FFFE then 3 more
        for (int i = 0; i < 65533; i++) begin
            @(posedge clk);
        end
        #1;
        chk("sat_fffe", 32'(cycle_cnt), 32'hFFFE);
        tick();
        tick();
        tick();
        chk("sat_cycle", 32'(cycle_cnt), 32'hFFFF);
        chk("sat_retired", 32'(retired_cnt), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
